// File: rtl/pipe_reg_chain_pkg.sv
// Shared defaults and helpers for the elastic register pipeline.
package pipe_reg_chain_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_STAGES = 3;

  // Bits needed to represent values 0..n, used for the occupancy count.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) <= n) w++;
    return w;
  endfunction

endpackage

// File: rtl/pipe_reg_chain_if.sv
// Producer/consumer handshake bundle of the elastic pipeline.
interface pipe_reg_chain_if
  import pipe_reg_chain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW  = cnt_width(DEF_STAGES)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNTW-1:0]  count;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_reg_chain_stage.sv
// One pipeline slot: a valid flag plus a data word that only updates on valid loads.
module pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  input  logic             clr_all,
  input  logic             clr_valid,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Flush drops the valid flag but leaves the data register untouched.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_valid) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = src_valid;
      if (src_valid) data_d = src_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_all) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic register pipeline with bubble collapsing; in_ready depends combinationally
// on out_ready, so integrators must account for that path.
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_reg_chain_if.slave  bus
);
  localparam int CNTW = cnt_width(STAGES);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] rdy;
  logic [WIDTH-1:0]  d [STAGES];
  logic [CNTW-1:0]   cnt;

  // A slot may load if it is empty or everything downstream of it can move.
  always_comb begin
    logic acc;
    rdy = '0;
    acc = bus.out_ready | ~v[STAGES-1];
    rdy[STAGES-1] = acc;
    for (int k = STAGES - 2; k >= 0; k--) begin
      acc    = acc | ~v[k];
      rdy[k] = acc;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    logic             sv;
    logic [WIDTH-1:0] sd;

    if (k == 0) begin : g_head
      assign sv = bus.in_valid;
      assign sd = bus.in_data;
    end else begin : g_body
      assign sv = v[k-1];
      assign sd = d[k-1];
    end

    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .load      (rdy[k]),
      .src_valid (sv),
      .src_data  (sd),
      .clr_all   (reset),
      .clr_valid (flush),
      .valid_o   (v[k]),
      .data_o    (d[k])
    );
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < STAGES; k++) cnt = cnt + CNTW'(v[k]);
  end

  assign bus.in_ready  = rdy[0] & ~flush;
  assign bus.out_valid = v[STAGES-1];
  assign bus.out_data  = d[STAGES-1];
  assign bus.count     = cnt;
endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain (WIDTH=8, STAGES=3) with a FIFO scoreboard.
module tb_pipe_reg_chain;
  import pipe_reg_chain_pkg::*;

  localparam int W = 8;
  localparam int S = 3;
  localparam int CW = cnt_width(S);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  int checks = 0;
  int failures = 0;
  int n_pop = 0;
  bit seen_77 = 1'b0;
  bit clr_pend = 1'b0;
  logic [W-1:0] exp_q [$];

  pipe_reg_chain_if #(.WIDTH(W), .CNTW(CW)) bus ();

  pipe_reg_chain #(.WIDTH(W), .STAGES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: a transfer seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      n_pop++;
      if (bus.out_data == 8'h77) seen_77 = 1'b1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got 0x%0h expected nothing", bus.out_data);
      end else begin
        chk("out_word", int'(bus.out_data), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy,
                       input logic fl, input logic rs);
    @(posedge clk);
    if (clr_pend) begin
      exp_q.delete();
      clr_pend = 1'b0;
    end
    #1;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    flush = fl;
    reset = rs;
    @(negedge clk);
    if (rs || fl) clr_pend = 1'b1;
    else if (iv && bus.in_ready) exp_q.push_back(id);
  endtask

  task automatic drain();
    for (int i = 0; i < S + 2; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("drain_count", int'(bus.count), 0);
    chk("drain_out_valid", int'(bus.out_valid), 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // 1: reset with random inputs
    for (int i = 0; i < 2; i++)
      drive(1'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);

    // 2: streaming
    drive(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h04, 1'b1, 1'b0, 1'b0);
    chk("stream_latency_valid", int'(bus.out_valid), 1);
    chk("stream_latency_data", int'(bus.out_data), 'h01);
    chk("stream_count", int'(bus.count), 3);
    drive(1'b1, 8'h05, 1'b1, 1'b0, 1'b0);
    chk("stream_next_data", int'(bus.out_data), 'h02);
    chk("stream_count2", int'(bus.count), 3);
    chk("stream_in_ready", int'(bus.in_ready), 1);
    drain();

    // 3: backpressure
    drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    chk("bp_count0", int'(bus.count), 0);
    chk("bp_in_ready0", int'(bus.in_ready), 1);
    drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    chk("bp_count2", int'(bus.count), 2);
    chk("bp_in_ready2", int'(bus.in_ready), 1);
    drive(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    chk("bp_full_count", int'(bus.count), 3);
    chk("bp_full_in_ready", int'(bus.in_ready), 0);
    chk("bp_full_data", int'(bus.out_data), 'h11);
    drive(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    chk("bp_hold_in_ready", int'(bus.in_ready), 0);
    chk("bp_hold_count", int'(bus.count), 3);
    drive(1'b1, 8'h44, 1'b1, 1'b0, 1'b0);
    chk("bp_release_in_ready", int'(bus.in_ready), 1);
    chk("bp_release_count", int'(bus.count), 3);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("bp_after_count", int'(bus.count), 3);
    chk("bp_after_data", int'(bus.out_data), 'h22);
    drain();

    // 4: bubble collapse
    drive(1'b1, 8'hA0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hB0, 1'b0, 1'b0, 1'b0);
    chk("bub_count1", int'(bus.count), 1);
    chk("bub_head_data", int'(bus.out_data), 'hA0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("bub_count2", int'(bus.count), 2);
    chk("bub_out_valid", int'(bus.out_valid), 1);
    chk("bub_out_data", int'(bus.out_data), 'hA0);
    chk("bub_in_ready", int'(bus.in_ready), 1);
    drain();

    // 5: flush
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    chk("fl_in_ready", int'(bus.in_ready), 0);
    chk("fl_count_before", int'(bus.count), 3);
    chk("fl_out_valid_before", int'(bus.out_valid), 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("fl_count_after", int'(bus.count), 0);
    chk("fl_out_valid_after", int'(bus.out_valid), 0);
    drain();
    chk("fl_no_77", int'(seen_77), 0);

    // 5b: consumer transfer during the flush cycle still counts
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("flt_out_data", int'(bus.out_data), 'h01);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("flt_count_after", int'(bus.count), 0);
    drain();

    // 6: reset mid-stream
    drive(1'b1, 8'h61, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h62, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h63, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h64, 1'b1, 1'b0, 1'b0);
    chk("mr_full_count", int'(bus.count), 3);
    drive(1'b1, 8'h65, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("mr_count", int'(bus.count), 0);
    chk("mr_out_valid", int'(bus.out_valid), 0);
    chk("mr_out_data", int'(bus.out_data), 0);
    chk("mr_in_ready", int'(bus.in_ready), 1);
    drive(1'b1, 8'h91, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("mr_lat_valid1", int'(bus.out_valid), 0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("mr_lat_valid2", int'(bus.out_valid), 0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("mr_lat_valid3", int'(bus.out_valid), 1);
    chk("mr_lat_data", int'(bus.out_data), 'h91);
    drain();

    chk("total_words_out", n_pop, 14);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised, elastic register pipeline: STAGES register slots of WIDTH bits, each with its own valid bit.
- Uses a valid/ready handshake on both sides and collapses bubbles. An empty slot accepts data even while the stages after it are stalled.
- Successor to the plain N-bit D-flop register. Used as a retiming and buffering stage between producer/consumer blocks that may stall.

Parameters:
- WIDTH, 8, data bits per slot (>=1)
- STAGES, 3, number of register slots (>=1)
- CNTW, $clog2(STAGES+1), width of the occupancy count (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous clear of all slots
- in_valid  input  1  producer offers in_data
- in_ready  output  1  chain accepts in_data this cycle
- in_data  input  WIDTH  input word
- out_valid  output  1  last slot holds a word
- out_ready  input  1  consumer takes out_data this cycle
- out_data  output  WIDTH  word in last slot
- count  output  CNTW  number of valid slots

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). Both are fixed.
- Slots are numbered 0 (input side) to STAGES-1 (output side). Slot k holds v[k] and d[k].
- out_valid = v[STAGES-1]; out_data = d[STAGES-1].
- rdy[STAGES-1] = out_ready | ~v[STAGES-1].
- rdy[k] = ~v[k] | rdy[k+1].
- in_ready = rdy[0] & ~flush.
- This is a combinational path from out_ready to in_ready. It is intentional and must be documented at integration.
- Transfer at input: in_valid & in_ready. Transfer at output: out_valid & out_ready.
- At each rising edge with no reset and no flush, for every k with rdy[k]=1:
  - v[k] <= source valid. For k=0 the source valid is in_valid; for k>0 it is v[k-1].
  - d[k] <= source data, but only when source valid = 1. Otherwise d[k] holds.
- For every k with rdy[k]=0, slot k holds.
- Latency (pipe empty, out_ready=1): a word accepted at edge N is on out_data with out_valid=1 after edge N+STAGES-1. With STAGES=1 it is visible right after the accepting edge.
- Throughput: one word per cycle while out_ready=1. Order is strictly FIFO; no word is dropped or duplicated.
- Full chain (all v=1):
  - with out_ready=0: in_ready=0.
  - with out_ready=1: in_ready=1, and accept and emit happen at the same edge, so count is unchanged.
- count is the combinational popcount of v, range 0..STAGES.
- reset=1 at an edge: all v<=0 and all d<=0. Reset has priority over flush and handshakes. After reset, out_valid=0, out_data=0, count=0, in_ready=1 (when flush=0).
- flush=1 at an edge: all v<=0 and d holds. in_ready=0 during the flush cycle, so the offered word is not accepted. out_valid still reflects the current state combinationally, but a consumer transfer in the flush cycle is allowed and counts as a taken word.
- Reset or flush asserted mid-operation discards all in-flight words. There is no partial state.
- in_data/in_valid changing while in_ready=0 must not change any slot.

Decomposition:
- Shared include file: default WIDTH/STAGES constants and a clog2 function for CNTW.
- One sub-module, pipe_stage: a single slot holding the valid flag and WIDTH-bit data register, with inputs load, src_valid, src_data, clr_all, clr_valid.
- pipe_reg_chain instantiates STAGES copies of pipe_stage with a generate loop, builds the rdy chain, and computes the popcount.

Test Plan (WIDTH=8, STAGES=3):
1. Reset: hold reset for 2 cycles with random inputs -> out_valid=0, out_data=0x00, count=0, in_ready=1 after release.
2. Streaming: out_ready=1, push 0x01..0x05 on consecutive edges starting at edge 1 -> 0x01 appears after edge 3, then 0x02..0x05 one per cycle in order; count steady at 3 mid-stream.
3. Backpressure: out_ready=0, offer 0x11, 0x22, 0x33, 0x44 -> first three accepted, count=3, in_ready=0 with 0x44 held. Then raise out_ready for one cycle -> 0x11 taken, in_ready=1 in the same cycle, 0x44 accepted at that edge, count stays 3, out_data=0x22 next.
4. Bubble collapse: out_ready=0, push 0xA0, idle 2 cycles, push 0xB0 -> 0xA0 at the output slot, 0xB0 in slot 1, count=2, in_ready=1.
5. Flush: chain full (0x01, 0x02, 0x03), flush=1 with in_valid=1, in_data=0x77 -> in_ready=0 that cycle; next cycle count=0 and out_valid=0. 0x77 never emerges.
6. Reset mid-stream: chain full and streaming, pulse reset for 1 cycle -> all slots empty, out_data=0x00. Post-reset pushes emerge with latency per scenario 2.
